// File: rtl/project_select_pkg.sv
// Shared types and constants for the project-select sequencer.
package project_select_pkg;

  localparam int unsigned PROJ_ID_W = 3;
  localparam int unsigned NONE_ID   = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/project_select_ctrl_if.sv
// Request handshake and enable/status bundle between management side and sequencer.
interface project_select_ctrl_if
  import project_select_pkg::*;
#(
  parameter int unsigned NUM_PROJECTS = 4,
  parameter int unsigned ID_W         = PROJ_ID_W
);

  logic                    req_valid;
  logic [ID_W-1:0]         req_id;
  logic                    req_ready;
  logic [NUM_PROJECTS-1:0] active;
  logic [ID_W-1:0]         cur_id;
  logic                    busy;
  logic                    done;
  logic                    err;

  modport master (
    output req_valid, req_id,
    input  req_ready, active, cur_id, busy, done, err
  );

  modport slave (
    input  req_valid, req_id,
    output req_ready, active, cur_id, busy, done, err
  );

endinterface

// File: rtl/proj_onehot_dec.sv
// Project ID to one-hot enable decode; ID 0 or out-of-range IDs give all zeros.
module proj_onehot_dec #(
  parameter int unsigned NUM_PROJECTS = 4,
  parameter int unsigned ID_W         = 3
) (
  input  logic [ID_W-1:0]         id,
  output logic [NUM_PROJECTS-1:0] onehot_c
);

  always_comb begin
    onehot_c = '0;
    for (int unsigned k = 1; k <= NUM_PROJECTS; k++) begin
      if (id == ID_W'(k)) onehot_c[k-1] = 1'b1;
    end
  end

endmodule

// File: rtl/project_select_ctrl.sv
// Owns the per-project enables: drains all enables for a guard interval on
// every switch so at most one project ever drives the shared buses.
module project_select_ctrl
  import project_select_pkg::*;
#(
  parameter int unsigned NUM_PROJECTS = 4,
  parameter int unsigned ID_W         = PROJ_ID_W,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned RESET_ID     = 0
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_n,
  project_select_ctrl_if.slave sel
);

  localparam int unsigned CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [NUM_PROJECTS-1:0] RESET_ACTIVE =
    (RESET_ID == NONE_ID) ? '0 : (NUM_PROJECTS'(1) << (RESET_ID - 1));

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_PROJECTS-1:0] dec_onehot_c;

  // cur_id already holds the target while draining, so decode it directly.
  proj_onehot_dec #(
    .NUM_PROJECTS (NUM_PROJECTS),
    .ID_W         (ID_W)
  ) u_dec (
    .id       (sel.cur_id),
    .onehot_c (dec_onehot_c)
  );

  assign sel.req_ready = (state == IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      sel.active <= RESET_ACTIVE;
      sel.cur_id <= ID_W'(RESET_ID);
      sel.busy   <= 1'b0;
      sel.done   <= 1'b0;
      sel.err    <= 1'b0;
    end else begin
      sel.done <= 1'b0;
      sel.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (sel.req_valid) begin
            if (sel.req_id > ID_W'(NUM_PROJECTS)) begin
              sel.err <= 1'b1;
            end else if (sel.req_id == sel.cur_id) begin
              sel.done <= 1'b1;
            end else begin
              sel.active <= '0;
              sel.cur_id <= sel.req_id;
              sel.busy   <= 1'b1;
              cnt        <= CNT_W'(GUARD_CYCLES - 1);
              state      <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            sel.active <= dec_onehot_c;
            sel.done   <= 1'b1;
            sel.busy   <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_project_select_ctrl.sv
// Self-checking bench: directed and random select traffic against a cycle-count model.
module tb_project_select_ctrl;

  localparam int unsigned N   = 4;
  localparam int unsigned IDW = 3;
  localparam int unsigned G   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n;
  logic rst_b_n;

  project_select_ctrl_if #(.NUM_PROJECTS(N), .ID_W(IDW)) ifa ();
  project_select_ctrl_if #(.NUM_PROJECTS(N), .ID_W(IDW)) ifb ();

  project_select_ctrl #(
    .NUM_PROJECTS (N), .ID_W (IDW), .GUARD_CYCLES (G), .RESET_ID (0)
  ) dut_a (
    .wb_clk_i (clk),
    .wb_rst_n (rst_a_n),
    .sel      (ifa)
  );

  project_select_ctrl #(
    .NUM_PROJECTS (N), .ID_W (IDW), .GUARD_CYCLES (G), .RESET_ID (1)
  ) dut_b (
    .wb_clk_i (clk),
    .wb_rst_n (rst_b_n),
    .sel      (ifb)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: enabled project and number of all-off cycles still to show.
  int   m_cur;
  int   m_left;
  logic m_done;
  logic m_err;

  function automatic logic [N-1:0] oh(int id);
    logic [N-1:0] one;
    one = N'(1);
    if (id <= 0 || id > int'(N)) return '0;
    return one << (id - 1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a();
    chk("a_active",  32'(ifa.active), (m_left > 0) ? 32'd0 : 32'(oh(m_cur)));
    chk("a_cur_id",  32'(ifa.cur_id), 32'(m_cur));
    chk("a_busy",    32'(ifa.busy),   (m_left > 0) ? 32'd1 : 32'd0);
    chk("a_ready",   32'(ifa.req_ready), (m_left == 0) ? 32'd1 : 32'd0);
    chk("a_done",    32'(ifa.done),   32'(m_done));
    chk("a_err",     32'(ifa.err),    32'(m_err));
    chk("a_onehot0", 32'($onehot0(ifa.active)), 32'd1);
  endtask

  task automatic model_step(logic v, int id);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (v) begin
      if (id > int'(N))    m_err = 1'b1;
      else if (id == m_cur) m_done = 1'b1;
      else begin
        m_cur  = id;
        m_left = int'(G);
      end
    end
  endtask

  task automatic cyc_a(logic v, int id);
    ifa.req_valid = v;
    ifa.req_id    = IDW'(id);
    @(posedge clk);
    model_step(v, id);
    @(negedge clk);
    check_a();
  endtask

  task automatic idle_a(int n);
    for (int i = 0; i < n; i++) cyc_a(1'b0, 0);
  endtask

  task automatic reset_a();
    ifa.req_valid = 1'b0;
    ifa.req_id    = '0;
    rst_a_n       = 1'b0;
    @(posedge clk);
    m_cur  = 0;
    m_left = 0;
    m_done = 1'b0;
    m_err  = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    check_a();
  endtask

  logic hv;
  int   hid;
  logic pend;
  logic rdy;

  initial begin
    rst_a_n       = 1'b0;
    rst_b_n       = 1'b0;
    ifa.req_valid = 1'b0;
    ifa.req_id    = '0;
    ifb.req_valid = 1'b0;
    ifb.req_id    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b_n = 1'b1;

    // RESET_ID=1 instance: reset values, then reset in the second drain cycle.
    chk("b_rst_active", 32'(ifb.active), 32'h1);
    chk("b_rst_cur_id", 32'(ifb.cur_id), 32'd1);
    chk("b_rst_ready",  32'(ifb.req_ready), 32'd1);
    ifb.req_valid = 1'b1;
    ifb.req_id    = 3'd3;
    @(posedge clk);
    @(negedge clk);
    ifb.req_valid = 1'b0;
    chk("b_drain1_busy",   32'(ifb.busy),   32'd1);
    chk("b_drain1_active", 32'(ifb.active), 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("b_drain2_busy", 32'(ifb.busy), 32'd1);
    rst_b_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_b_n = 1'b1;
    chk("b_abort_active", 32'(ifb.active), 32'h1);
    chk("b_abort_busy",   32'(ifb.busy),   32'd0);
    chk("b_abort_done",   32'(ifb.done),   32'd0);
    chk("b_abort_cur_id", 32'(ifb.cur_id), 32'd1);
    chk("b_abort_ready",  32'(ifb.req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("b_after_done",   32'(ifb.done),   32'd0);
      chk("b_after_active", 32'(ifb.active), 32'h1);
    end

    // RESET_ID=0 instance: directed switch scenarios.
    reset_a();
    cyc_a(1'b1, 2);
    idle_a(6);
    cyc_a(1'b1, 4);
    idle_a(6);
    cyc_a(1'b1, 3);
    idle_a(6);
    cyc_a(1'b1, 3);
    cyc_a(1'b1, 5);
    cyc_a(1'b1, 7);
    cyc_a(1'b0, 0);
    cyc_a(1'b1, 1);
    for (int i = 0; i < 10; i++) cyc_a(1'b1, 3);
    idle_a(3);
    chk("a_hold_active", 32'(ifa.active), 32'h4);
    cyc_a(1'b1, 2);
    idle_a(6);
    cyc_a(1'b1, 0);
    idle_a(6);
    chk("a_none_cur_id", 32'(ifa.cur_id), 32'd0);
    chk("a_none_active", 32'(ifa.active), 32'h0);

    // Random traffic; a request is held stable until accepted.
    pend = 1'b0;
    hv   = 1'b0;
    hid  = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset_a();
        pend = 1'b0;
      end else begin
        if (!pend) begin
          hv  = ($urandom_range(0, 2) != 0);
          hid = int'($urandom_range(0, 7));
        end
        rdy = (m_left == 0);
        cyc_a(hv, hid);
        pend = hv && !rdy;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
